// File: rtl/smash_pkg.sv
// smash_pkg: definitions shared by the damage arbiter slice.
//   - issue-sequencer state encoding
//   - percent width, saturation ceiling and invulnerability length defaults
//   - attack vector bit positions
//   - saturating percent adder
package smash_pkg;

  localparam int PCT_W             = 10;
  localparam int MAX_PCT_DEF       = 999;
  localparam int INVULN_CYCLES_DEF = 60;

  // Attack vector bit positions
  localparam int ATK_CONTACT   = 0;
  localparam int ATK_A         = 5;
  localparam int ATK_UP_B      = 6;
  localparam int ATK_DOWN_B    = 7;
  localparam int ATK_SIDE_B_LO = 8;
  localparam int ATK_SIDE_B_HI = 9;
  localparam int ATK_B         = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  // Saturating add of a 32-bit damage value onto a percent.
  // Any damage at or above the ceiling saturates outright, so the upper
  // damage bits never need to enter the adder; the low bits are summed
  // one bit wider than a percent so the carry is seen by the clamp.
  function automatic logic [PCT_W-1:0] pct_add(
    input logic [PCT_W-1:0] pct,
    input logic [31:0]      dmg,
    input logic [PCT_W-1:0] max_pct
  );
    logic [PCT_W:0] sum;
    sum = {1'b0, pct} + {1'b0, dmg[PCT_W-1:0]};
    if (dmg >= {{(32-PCT_W){1'b0}}, max_pct}) begin
      pct_add = max_pct;
    end else if (sum > {1'b0, max_pct}) begin
      pct_add = max_pct;
    end else begin
      pct_add = sum[PCT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   i_clock   system clock
//   i_reset_n asynchronous active-low reset (pointer -> requester 0)
//   i_en      arbitration allowed this cycle
//   i_req     request vector, bit i = requester i
//   o_gnt     one-hot grant, valid in the same cycle as i_req/i_en
// With both requesting, the pointer's requester wins; a lone requester
// always wins. The pointer moves to the other requester on every grant.
module rr_arbiter2 (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // Grant selection
  always_comb begin
    o_gnt = 2'b00;
    if (!i_en) begin
      o_gnt = 2'b00;
    end else if (i_req == 2'b11) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

  // Pointer moves to the player that was not just granted
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/damage_arbiter.sv
// damage_arbiter: shares the damage coprocessor between two players and
// accumulates each player's damage percent.
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_req0/1, i_attack0/1     attack requests (held until ack) and vectors
//   o_ack0/1                  one-cycle grant acknowledge
//   o_cop_attack, i_cop_damage coprocessor attack out / damage back (1 cycle)
//   i_clear0/1                stock lost: zero percent and invulnerability
//   o_pct0/1, o_invuln0/1     damage percent and invulnerability per player
//   o_hit_valid/target/amount one-cycle report of applied damage
// Player i's attack always lands on player 1-i.
module damage_arbiter
  import smash_pkg::*;
#(
  parameter int MAX_PCT       = MAX_PCT_DEF,
  parameter int INVULN_CYCLES = INVULN_CYCLES_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [31:0]      i_attack0,
  input  logic [31:0]      i_attack1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic [31:0]      o_cop_attack,
  input  logic [31:0]      i_cop_damage,
  input  logic             i_clear0,
  input  logic             i_clear1,
  output logic [PCT_W-1:0] o_pct0,
  output logic [PCT_W-1:0] o_pct1,
  output logic             o_invuln0,
  output logic             o_invuln1,
  output logic             o_hit_valid,
  output logic             o_hit_target,
  output logic [7:0]       o_hit_amount
);

  localparam int                     CNT_W     = $clog2(INVULN_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(INVULN_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [PCT_W-1:0]       MAX_PCT_L = PCT_W'(MAX_PCT);

  state_e           r_state, w_state_nxt;
  logic [1:0]       w_gnt;
  logic [1:0]       w_clear;
  logic             r_tgt, w_tgt_nxt;
  logic [1:0]       r_ack, w_ack_nxt;
  logic [31:0]      r_cop_attack, w_cop_nxt;
  logic             w_hit;
  logic [7:0]       w_hit_amt;
  logic             r_hit_valid, r_hit_tgt;
  logic [7:0]       r_hit_amt;
  logic [PCT_W-1:0] r_pct [2];
  logic [PCT_W-1:0] w_pct_nxt [2];
  logic [CNT_W-1:0] r_cnt [2];
  logic [CNT_W-1:0] w_cnt_nxt [2];
  logic [1:0]       r_invuln;

  assign w_clear   = {i_clear1, i_clear0};
  assign w_hit_amt = (i_cop_damage > 32'd255) ? 8'd255 : i_cop_damage[7:0];

  rr_arbiter2 u_rr (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_en      (r_state == ST_IDLE),
    .i_req     ({i_req1, i_req0}),
    .o_gnt     (w_gnt)
  );

  // Sequencer state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next state: IDLE -> ISSUE on a grant, then APPLY, then IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt != 2'b00) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_APPLY;
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer outputs: next ack / coprocessor vector / target, hit decision
  always_comb begin
    w_ack_nxt = 2'b00;
    w_cop_nxt = 32'd0;
    w_tgt_nxt = r_tgt;
    w_hit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt[0]) begin
          w_ack_nxt = 2'b01;
          w_cop_nxt = i_attack0;
          w_tgt_nxt = 1'b1;
        end else if (w_gnt[1]) begin
          w_ack_nxt = 2'b10;
          w_cop_nxt = i_attack1;
          w_tgt_nxt = 1'b0;
        end else begin
          w_tgt_nxt = r_tgt;
        end
      end
      ST_ISSUE: w_hit = 1'b0;
      ST_APPLY: w_hit = (i_cop_damage != 32'd0) && !r_invuln[r_tgt];
      default:  w_hit = 1'b0;
    endcase
  end

  // Per-player percent and invulnerability next values; clear beats a hit
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_pct_nxt[p] = r_pct[p];
      w_cnt_nxt[p] = r_cnt[p];
      if (w_clear[p]) begin
        w_pct_nxt[p] = {PCT_W{1'b0}};
        w_cnt_nxt[p] = CNT_ZERO;
      end else if (w_hit && (r_tgt == 1'(p))) begin
        w_pct_nxt[p] = pct_add(r_pct[p], i_cop_damage, MAX_PCT_L);
        w_cnt_nxt[p] = CNT_LOAD;
      end else if (r_cnt[p] != CNT_ZERO) begin
        w_cnt_nxt[p] = r_cnt[p] - CNT_ONE;
      end else begin
        w_cnt_nxt[p] = CNT_ZERO;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tgt        <= 1'b0;
      r_ack        <= 2'b00;
      r_cop_attack <= 32'd0;
      r_hit_valid  <= 1'b0;
      r_hit_tgt    <= 1'b0;
      r_hit_amt    <= 8'd0;
      r_invuln     <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        r_pct[p] <= {PCT_W{1'b0}};
        r_cnt[p] <= CNT_ZERO;
      end
    end else begin
      r_tgt        <= w_tgt_nxt;
      r_ack        <= w_ack_nxt;
      r_cop_attack <= w_cop_nxt;
      r_hit_valid  <= w_hit;
      if (w_hit) begin
        r_hit_tgt <= r_tgt;
        r_hit_amt <= w_hit_amt;
      end else begin
        r_hit_tgt <= r_hit_tgt;
        r_hit_amt <= 8'd0;
      end
      for (int p = 0; p < 2; p++) begin
        r_pct[p]    <= w_pct_nxt[p];
        r_cnt[p]    <= w_cnt_nxt[p];
        r_invuln[p] <= (w_cnt_nxt[p] != CNT_ZERO);
      end
    end
  end

  assign o_ack0       = r_ack[0];
  assign o_ack1       = r_ack[1];
  assign o_cop_attack = r_cop_attack;
  assign o_pct0       = r_pct[0];
  assign o_pct1       = r_pct[1];
  assign o_invuln0    = r_invuln[0];
  assign o_invuln1    = r_invuln[1];
  assign o_hit_valid  = r_hit_valid;
  assign o_hit_target = r_hit_tgt;
  assign o_hit_amount = r_hit_amt;

endmodule
